register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   32-entry x 32-bit general-purpose register file for the processor.
//   Sits downstream of the 5-to-32 write-select decoder. Consumes the
//   writeback stage's (enable, index, data) triple. Serves two
//   combinational read ports to decode/execute.
//   - r0 is hardwired to zero.
//   - Optional write-to-read bypass lets a same-cycle write be seen by readers.
// PARAMETERS
//   DATA_WIDTH  32  width of each register and of all data ports
//   ADDR_WIDTH  5   register index width; NUM_REGS = 2**ADDR_WIDTH (32)
//   BYPASS      1   1 = reads return data_writeReg on same-cycle index match; 0 = storage only
// PORTS
//   clock             in   1           single clock; all writes on rising edge
//   ctrl_reset        in   1           asynchronous, active-high reset
//   ctrl_writeEnable  in   1           write strobe from writeback
//   ctrl_writeReg     in   ADDR_WIDTH  destination register index
//   data_writeReg     in   DATA_WIDTH  write data
//   ctrl_readRegA     in   ADDR_WIDTH  read port A index
//   ctrl_readRegB     in   ADDR_WIDTH  read port B index
//   data_readRegA     out  DATA_WIDTH  read port A data (combinational)
//   data_readRegB     out  DATA_WIDTH  read port B data (combinational)
// BEHAVIOUR
//   - Clock and reset: one clock, `clock`; reset `ctrl_reset` is asynchronous, active-high.
//   - Reset:
//     - Asserting ctrl_reset immediately clears all registers r1..r31 to 0, with no clock needed.
//     - Both read outputs are 0 while reset is held. Bypass is suppressed during reset.
//     - A rising edge with ctrl_reset high performs no write; reset wins.
//     - Deassertion takes effect at the next rising edge; no synchronous release stage.
//   - Write:
//     - At the rising clock edge, if ctrl_writeEnable=1 and ctrl_writeReg!=0,
//       then reg[ctrl_writeReg] <= data_writeReg.
//     - Write select is the one-hot AND of the decoded index and ctrl_writeEnable.
//     - Exactly one register (or none) is updated per cycle.
//     - Writes to index 0 are silently discarded.
//   - Read (per port P in {A,B}; both ports are independent and identical):
//     1. ctrl_readRegP==0 -> data_readRegP = 0, regardless of the write.
//     2. Else if BYPASS=1 and ctrl_writeEnable=1 and ctrl_writeReg==ctrl_readRegP
//        -> data_readRegP = data_writeReg (same cycle, zero latency).
//     3. Else -> data_readRegP = reg[ctrl_readRegP], the value as of the last edge.
//   - Latency:
//     - Read: 0 cycles (pure combinational path from index to data).
//     - Write: visible from storage 1 edge later; with BYPASS=1 also visible in the write cycle.
//   - Boundary cases:
//     - Both ports may read the same index; both return the same value.
//     - Both ports may match the writer; both get the bypassed value.
//     - Index 31 behaves like every other non-zero register.
//     - A writeEnable=0 cycle leaves all storage unchanged, whatever the index/data inputs.
//     - X on ctrl_writeReg with writeEnable=0 must not corrupt storage.
//   - No handshake: writeback guarantees at most one write per cycle. The block never stalls.
// STRUCTURE
//   - Shared package:
//     - REG_ZERO = 5'd0.
//     - Default DATA_WIDTH/ADDR_WIDTH constants, shared with the decode stage and writeback mux.
//   - Sub-module decoder5to32: one-hot write select from ctrl_writeReg.
//     The enable AND is done here, not inside the decoder.
//   - Storage: generate loop over 1..NUM_REGS-1. Each entry is a DATA_WIDTH
//     flop bank with async clear and enable = sel[i] & ctrl_writeEnable.
//   - Read muxes: one NUM_REGS:1 mux per port, followed by zero-force and bypass logic.
// TESTING
//   1. Reset: pulse ctrl_reset mid-cycle with no clock edge. Read A=5, B=31
//      -> 0/0 immediately. Re-read after deassertion -> still 0.
//   2. Write/read: write r7=0xDEADBEEF, then next cycle read A=7
//      -> 0xDEADBEEF. Read B=8 -> 0.
//   3. r0 hardwiring: write r0=0xFFFFFFFF, then read A=0, B=0
//      -> 0 in both the same and the next cycle.
//   4. Bypass:
//      - BYPASS=1: write r12=0x12345678 while A=12, B=12 -> both 0x12345678 in the same cycle.
//      - BYPASS=0: same stimulus -> old value 0 that cycle, 0x12345678 next cycle.
//   5. Reset wins: ctrl_reset high across an edge with writeEnable=1 and r3=0xA5A5A5A5
//      -> r3 reads 0 after release.
//   6. Sweep: write reg[i]=i*0x01010101 for i=0..31, then read all pairs
//      -> r0=0, others match; no aliasing between indices.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants for the register file, decode stage and writeback mux.
package register_file_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NUM_REGS_DEF   = 2 ** ADDR_WIDTH_DEF;

    // Architectural zero register index.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : register_file_pkg

// File: rtl/decoder5to32.sv
// Index-to-one-hot decoder for the register file write select.
// The write-enable qualification is applied by the caller, not here.
module decoder5to32 #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_OUT    = 2 ** ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] idx_i,
    output logic [NUM_OUT-1:0]    sel_o
);

    // One-hot decode of the destination index.
    always_comb begin
        sel_o        = '0;
        sel_o[idx_i] = 1'b1;
    end

endmodule : decoder5to32

// File: rtl/register_file.sv
// 32 x 32 general-purpose register file: r0 hardwired to zero, one write
// port, two combinational read ports with optional same-cycle write bypass.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [NUM_REGS-1:0]                 dec_sel;
    logic [NUM_REGS-1:0]                 wr_en;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic                                unused_sel0;

    decoder5to32 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_OUT    (NUM_REGS)
    ) u_dec (
        .idx_i (ctrl_writeReg),
        .sel_o (dec_sel)
    );

    // Gating with writeEnable here keeps an unknown index harmless when idle.
    assign wr_en       = dec_sel & {NUM_REGS{ctrl_writeEnable}};
    assign unused_sel0 = wr_en[0];

    // r0 has no storage at all.
    assign regs_q[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] ent_q;
            logic [DATA_WIDTH-1:0] ent_d;

            assign ent_d = wr_en[gi] ? data_writeReg : ent_q;

            // Entry flop bank: async clear, loads only when selected.
            always_ff @(posedge clock or posedge ctrl_reset) begin
                if (ctrl_reset) ent_q <= '0;
                else            ent_q <= ent_d;
            end

            assign regs_q[gi] = ent_q;
        end
    endgenerate

    logic hit_a, hit_b;
    assign hit_a = (BYPASS != 0) && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA);
    assign hit_b = (BYPASS != 0) && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB);

    // Port A: zero-force for r0 and reset, then bypass, then storage.
    always_comb begin
        data_readRegA = '0;
        if (!ctrl_reset && ctrl_readRegA != ZERO_IDX) begin
            if (hit_a) data_readRegA = data_writeReg;
            else       data_readRegA = regs_q[ctrl_readRegA];
        end
    end

    // Port B: identical to port A.
    always_comb begin
        data_readRegB = '0;
        if (!ctrl_reset && ctrl_readRegB != ZERO_IDX) begin
            if (hit_b) data_readRegB = data_writeReg;
            else       data_readRegB = regs_q[ctrl_readRegB];
        end
    end

endmodule : register_file

// File: tb/tb_register_file.sv
// Bench for register_file: a bypassing and a non-bypassing instance share
// stimulus and are checked against an array-based register model.
module tb_register_file;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] a1, b1, a0, b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32];

    always #5 clock = ~clock;

    register_file #(.BYPASS(1)) dut_byp (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (a1),
        .data_readRegB    (b1)
    );

    register_file #(.BYPASS(0)) dut_nob (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (a0),
        .data_readRegB    (b0)
    );

    // Expected read value from the architectural rules.
    function automatic logic [31:0] expect_rd(input logic [4:0] idx, input bit byp);
        if (idx == 5'd0 || ctrl_reset) return 32'h0;
        if (byp && ctrl_writeEnable && ctrl_writeReg == idx) return data_writeReg;
        return mem[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "/byp.A"}, a1, expect_rd(ctrl_readRegA, 1'b1));
        chk({tag, "/byp.B"}, b1, expect_rd(ctrl_readRegB, 1'b1));
        chk({tag, "/nob.A"}, a0, expect_rd(ctrl_readRegA, 1'b0));
        chk({tag, "/nob.B"}, b0, expect_rd(ctrl_readRegB, 1'b0));
    endtask

    // One cycle: drive after negedge, check mid-cycle, update model at posedge.
    task automatic cyc(input string tag, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        #1;
        chk_all(tag);
        @(posedge clock);
        if (ctrl_reset) foreach (mem[i]) mem[i] = 32'h0;
        else if (we && wr != 5'd0) mem[wr] = wd;
        @(negedge clock);
    endtask

    initial begin
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_readRegA    = '0;
        ctrl_readRegB    = '0;
        foreach (mem[i]) mem[i] = 32'h0;
        #3 ctrl_reset = 1'b0;
        @(negedge clock);

        // Preload so the async clear has something to remove.
        cyc("pre5",  1'b1, 5'd5,  32'h5555_0005, 5'd0, 5'd0);
        cyc("pre31", 1'b1, 5'd31, 32'h3131_3131, 5'd5, 5'd31);

        // Reset pulse mid-cycle, no clock edge involved.
        ctrl_writeEnable = 1'b0;
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd31;
        #1 ctrl_reset = 1'b1;
        foreach (mem[i]) mem[i] = 32'h0;
        #1;
        chk_all("rst_async");
        ctrl_reset = 1'b0;
        #1;
        chk_all("rst_release");
        @(negedge clock);

        // Write then read back; neighbour untouched.
        cyc("w7",   1'b1, 5'd7, 32'hDEAD_BEEF, 5'd0, 5'd0);
        cyc("r7",   1'b0, 5'd0, 32'h0,         5'd7, 5'd8);

        // r0 hardwired.
        cyc("w0",   1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        cyc("r0",   1'b0, 5'd0, 32'h0,         5'd0, 5'd0);

        // Same-cycle bypass on both ports, then storage visible.
        cyc("byp12", 1'b1, 5'd12, 32'h1234_5678, 5'd12, 5'd12);
        cyc("r12",   1'b0, 5'd0,  32'h0,         5'd12, 5'd12);

        // Reset held across an edge with a write pending: reset wins.
        cyc("pre3", 1'b1, 5'd3, 32'h0000_0333, 5'd0, 5'd0);
        ctrl_reset = 1'b1;
        cyc("rstwin", 1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3);
        ctrl_reset = 1'b0;
        cyc("r3", 1'b0, 5'd0, 32'h0, 5'd3, 5'd12);

        // Idle cycle with unknown index must not disturb storage.
        cyc("pre9", 1'b1, 5'd9, 32'h0909_0909, 5'd0, 5'd0);
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'bx;
        data_writeReg    = 32'hCAFE_F00D;
        @(posedge clock);
        @(negedge clock);
        cyc("r9", 1'b0, 5'd0, 32'h0, 5'd9, 5'd7);

        // Sweep every index, then read all pairs.
        for (int i = 0; i < 32; i++)
            cyc("sweep_w", 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i), 5'(31 - i));
        for (int i = 0; i < 32; i++)
            cyc("sweep_r", 1'b0, 5'(i), 32'hFFFF_FFFF, 5'(i), 5'((i + 1) % 32));

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic [4:0]  wr, ra, rb;
            logic [31:0] wd;
            we = ($urandom_range(0, 3) != 0);
            wr = 5'($urandom_range(0, 31));
            wd = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            cyc("rand", we, wr, wd, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_file
